sd_wr_block_feeder: RTL and testbench

//  Upstream feeder for the SD single-block writer. Buffers a 16-bit pixel/packet stream into ping-pong
//  256x16 (512-byte) block buffers. For each full buffer: issues a write request with an incrementing sector

---
 rtl/sd_wr_pkg.sv | 17 +
 rtl/sd_pingpong_ram.sv | 26 ++
 rtl/sd_wr_block_feeder.sv | 189 ++++++++++++++++++
 tb/tb_sd_wr_block_feeder.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/sd_wr_pkg.sv
// Shared types and constants for the SD single-block write feeder.
package sd_wr_pkg;

  localparam int unsigned SD_BLOCK_BYTES   = 512;
  localparam int unsigned BLOCK_WORDS_DFLT = SD_BLOCK_BYTES / 2;
  localparam int unsigned BLOCK_WORDS_W    = $clog2(BLOCK_WORDS_DFLT);

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StIssue,
    StXfer,
    StRetire,
    StDone
  } state_e;

endpackage

// File: rtl/sd_pingpong_ram.sv
// Simple dual-port block buffer: one write port, one registered read port (1-cycle latency).
module sd_pingpong_ram #(
  parameter int unsigned AW = 9,
  parameter int unsigned DW = 16
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sd_wr_block_feeder.sv
// Ping-pong block feeder for the SD single-block writer.
// Define SD_WR_SEC_WRAP_EN for ring recording over the SEC_NUM sector window.
module sd_wr_block_feeder
  import sd_wr_pkg::*;
#(
  parameter int unsigned BLOCK_WORDS = BLOCK_WORDS_DFLT,
  parameter logic [31:0] START_SEC   = 32'd0,
  parameter logic [31:0] SEC_NUM     = 32'd1024
) (
  input  logic        clk_25m,
  input  logic        rst,
  input  logic        sd_init_done,
  input  logic        start,
  input  logic [15:0] din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic        wr_start_en,
  output logic [31:0] sec,
  input  logic        wr_busy,
  input  logic        wr_req,
  output logic [15:0] wr_data,
  input  logic        sd_block_wdone,
  output logic [31:0] blk_cnt,
  output logic        overflow,
  output logic        session_done
);

  localparam int unsigned PtrW = $clog2(BLOCK_WORDS);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(BLOCK_WORDS - 1);

  state_e            state_q, state_d;
  logic              open_q, open_d;
  logic [1:0]        full_q, full_d;
  logic              wb_q, wb_d, rb_q, rb_d;
  logic [PtrW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [31:0]       blk_cnt_q, blk_cnt_d, sec_off_q, sec_off_d, sec_q, sec_d;
  logic              wr_start_en_q, wr_start_en_d;
  logic              overflow_q, overflow_d;
  logic              done_q, done_d;
  logic              wdone_q;
  logic              accept, wdone_rise, open_session;
  logic [15:0]       ram_rdata;

  assign din_ready  = open_q && !full_q[wb_q] && !done_q;
  assign accept     = din_valid && din_ready;
  assign wdone_rise = sd_block_wdone && !wdone_q;

  always_comb begin
    state_d       = state_q;
    open_d        = open_q;
    full_d        = full_q;
    wb_d          = wb_q;
    rb_d          = rb_q;
    wptr_d        = wptr_q;
    rptr_d        = rptr_q;
    blk_cnt_d     = blk_cnt_q;
    sec_off_d     = sec_off_q;
    sec_d         = sec_q;
    wr_start_en_d = wr_start_en_q;
    overflow_d    = overflow_q;
    done_d        = done_q;
    open_session  = 1'b0;

    if (accept) begin
      wptr_d = wptr_q + 1'b1;
      if (wptr_q == LastPtr) begin
        full_d[wb_q] = 1'b1;
        wb_d         = ~wb_q;
      end
    end
    if (din_valid && !din_ready && open_q) begin
      overflow_d = 1'b1;
    end

    case (state_q)
      StIdle: open_session = start;
      StArm: begin
        if (full_q[rb_q] && sd_init_done && !wr_busy) begin
          state_d       = StIssue;
          sec_d         = START_SEC + sec_off_q;
          wr_start_en_d = 1'b1;
        end
      end
      StIssue: begin
        if (wr_busy) begin
          state_d       = StXfer;
          wr_start_en_d = 1'b0;
        end
      end
      StXfer: begin
        // Saturate on the last word so over-pulls keep returning it.
        if (wr_req && rptr_q != LastPtr) begin
          rptr_d = rptr_q + 1'b1;
        end
        if (wdone_rise) begin
          state_d = StRetire;
        end
      end
      StRetire: begin
        full_d[rb_q] = 1'b0;
        rb_d         = ~rb_q;
        rptr_d       = '0;
        blk_cnt_d    = blk_cnt_q + 32'd1;
        state_d      = StArm;
`ifdef SD_WR_SEC_WRAP_EN
        sec_off_d = (sec_off_q == SEC_NUM - 32'd1) ? 32'd0 : sec_off_q + 32'd1;
`else
        sec_off_d = sec_off_q + 32'd1;
        if (blk_cnt_q + 32'd1 == SEC_NUM) begin
          state_d = StDone;
          done_d  = 1'b1;
        end
`endif
      end
      StDone:  open_session = start;
      default: state_d = StIdle;
    endcase

    if (open_session) begin
      state_d       = StArm;
      open_d        = 1'b1;
      full_d        = '0;
      wb_d          = 1'b0;
      rb_d          = 1'b0;
      wptr_d        = '0;
      rptr_d        = '0;
      blk_cnt_d     = '0;
      sec_off_d     = '0;
      wr_start_en_d = 1'b0;
      overflow_d    = 1'b0;
      done_d        = 1'b0;
    end
  end

  always_ff @(posedge clk_25m) begin
    if (rst) begin
      state_q       <= StIdle;
      open_q        <= 1'b0;
      full_q        <= '0;
      wb_q          <= 1'b0;
      rb_q          <= 1'b0;
      wptr_q        <= '0;
      rptr_q        <= '0;
      blk_cnt_q     <= '0;
      sec_off_q     <= '0;
      sec_q         <= '0;
      wr_start_en_q <= 1'b0;
      overflow_q    <= 1'b0;
      done_q        <= 1'b0;
      wdone_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      open_q        <= open_d;
      full_q        <= full_d;
      wb_q          <= wb_d;
      rb_q          <= rb_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      blk_cnt_q     <= blk_cnt_d;
      sec_off_q     <= sec_off_d;
      sec_q         <= sec_d;
      wr_start_en_q <= wr_start_en_d;
      overflow_q    <= overflow_d;
      done_q        <= done_d;
      wdone_q       <= sd_block_wdone;
    end
  end

  // Read address runs continuously, so word 0 is already prefetched when ISSUE is entered.
  sd_pingpong_ram #(
    .AW(PtrW + 1),
    .DW(16)
  ) u_ram (
    .clk_i  (clk_25m),
    .we_i   (accept),
    .waddr_i({wb_q, wptr_q}),
    .wdata_i(din),
    .raddr_i({rb_q, rptr_q}),
    .rdata_o(ram_rdata)
  );

  assign wr_data      = (state_q == StIssue || state_q == StXfer) ? ram_rdata : 16'd0;
  assign wr_start_en  = wr_start_en_q;
  assign sec          = sec_q;
  assign blk_cnt      = blk_cnt_q;
  assign overflow     = overflow_q;
  assign session_done = done_q;

endmodule

// File: tb/tb_sd_wr_block_feeder.sv
// Directed bench for sd_wr_block_feeder with a simple negedge SD-writer model.
module tb_sd_wr_block_feeder;

  localparam logic [31:0] StartSec = 32'd100;
  localparam logic [31:0] SecNum   = 32'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sd_init_done = 1'b1;
  logic        start = 1'b0;
  logic [15:0] din = '0;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic        wr_start_en;
  logic [31:0] sec;
  logic        wr_busy = 1'b0;
  logic        wr_req = 1'b0;
  logic [15:0] wr_data;
  logic        sd_block_wdone = 1'b0;
  logic [31:0] blk_cnt;
  logic        overflow;
  logic        session_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sd_wr_block_feeder #(
    .BLOCK_WORDS(256),
    .START_SEC  (StartSec),
    .SEC_NUM    (SecNum)
  ) dut (
    .clk_25m       (clk),
    .rst           (rst),
    .sd_init_done  (sd_init_done),
    .start         (start),
    .din           (din),
    .din_valid     (din_valid),
    .din_ready     (din_ready),
    .wr_start_en   (wr_start_en),
    .sec           (sec),
    .wr_busy       (wr_busy),
    .wr_req        (wr_req),
    .wr_data       (wr_data),
    .sd_block_wdone(sd_block_wdone),
    .blk_cnt       (blk_cnt),
    .overflow      (overflow),
    .session_done  (session_done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; din_valid = 1'b0; wr_req = 1'b0; wr_busy = 1'b0;
    sd_block_wdone = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push_words(input string tag, input logic [15:0] base, input int n);
    int   i   = 0;
    int   tmo = 0;
    logic rdy;
    while (i < n && tmo < 1000) begin
      din       = base + 16'(i);
      din_valid = 1'b1;
      rdy       = din_ready;
      @(negedge clk);
      if (rdy) i++;
      else tmo++;
    end
    din_valid = 1'b0;
    check_eq({tag, " accepted"}, i, n);
  endtask

  // Writer model: read the current word, pulse wr_req, then allow two posedges for the next word.
  task automatic serve_block(input string tag, input logic [31:0] exp_sec,
                             input logic [15:0] base, input logic [31:0] exp_blk);
    int n   = 0;
    int bad = 0;
    while (!wr_start_en && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, " req"}, wr_start_en, 1);
    check_eq({tag, " sec"}, sec, exp_sec);
    wr_busy = 1'b1;
    @(negedge clk);
    check_eq({tag, " req drop"}, wr_start_en, 0);
    for (int i = 0; i < 256; i++) begin
      if (wr_data !== base + 16'(i)) bad++;
      wr_req = 1'b1;
      @(negedge clk);
      wr_req = 1'b0;
      repeat (2) @(negedge clk);
    end
    check_eq({tag, " data errs"}, bad, 0);
    check_eq({tag, " saturate"}, wr_data, base + 16'd255);
    sd_block_wdone = 1'b1;
    wr_busy        = 1'b0;
    repeat (2) @(negedge clk);
    sd_block_wdone = 1'b0;
    repeat (2) @(negedge clk);
    check_eq({tag, " blk_cnt"}, blk_cnt, exp_blk);
  endtask

  initial begin
    // Reset state and single-block path, then the full sector window.
    do_reset();
    check_eq("rst din_ready", din_ready, 0);
    check_eq("rst wr_start_en", wr_start_en, 0);
    check_eq("rst sec", sec, 0);
    check_eq("rst blk_cnt", blk_cnt, 0);
    check_eq("rst overflow", overflow, 0);
    check_eq("rst session_done", session_done, 0);
    check_eq("rst wr_data", wr_data, 0);
    pulse_start();
    check_eq("open din_ready", din_ready, 1);
    push_words("a0", 16'h0000, 256);
    serve_block("a0", 100, 16'h0000, 1);
    push_words("a1", 16'h0100, 256);
    serve_block("a1", 101, 16'h0100, 2);
    push_words("a2", 16'h0200, 256);
    serve_block("a2", 102, 16'h0200, 3);
`ifdef SD_WR_SEC_WRAP_EN
    check_eq("wrap session_done", session_done, 0);
    push_words("a3", 16'h0300, 256);
    serve_block("a3", 100, 16'h0300, 4);
`else
    check_eq("done session_done", session_done, 1);
    check_eq("done din_ready", din_ready, 0);
`endif

    // Writer stalled: both buffers fill, then backpressure and overflow.
    do_reset();
    pulse_start();
    wr_busy = 1'b1;
    push_words("b", 16'h1000, 512);
    check_eq("stall din_ready", din_ready, 0);
    check_eq("stall overflow pre", overflow, 0);
    check_eq("stall no req", wr_start_en, 0);
    din_valid = 1'b1;
    din       = 16'hdead;
    repeat (3) @(negedge clk);
    din_valid = 1'b0;
    check_eq("stall overflow", overflow, 1);
    wr_busy = 1'b0;
    serve_block("b0", 100, 16'h1000, 1);
    serve_block("b1", 101, 16'h1100, 2);

    // Request gated by sd_init_done, then back-to-back ping-pong order.
    do_reset();
    sd_init_done = 1'b0;
    pulse_start();
    push_words("c0", 16'h3000, 256);
    repeat (5) @(negedge clk);
    check_eq("init gate", wr_start_en, 0);
    sd_init_done = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("init release", wr_start_en, 1);
    serve_block("c0", 100, 16'h3000, 1);
    push_words("c12", 16'h3100, 512);
    serve_block("c1", 101, 16'h3100, 2);
    serve_block("c2", 102, 16'h3200, 3);

    // Reset in the middle of a transfer, then a fresh session.
    do_reset();
    pulse_start();
    push_words("d0", 16'h5000, 256);
    while (!wr_start_en) @(negedge clk);
    wr_busy = 1'b1;
    for (int i = 0; i < 100; i++) begin
      wr_req = 1'b1;
      @(negedge clk);
      wr_req = 1'b0;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst wr_start_en", wr_start_en, 0);
    check_eq("midrst din_ready", din_ready, 0);
    check_eq("midrst blk_cnt", blk_cnt, 0);
    check_eq("midrst wr_data", wr_data, 0);
    rst     = 1'b0;
    wr_busy = 1'b0;
    @(negedge clk);
    pulse_start();
    push_words("d1", 16'h6000, 256);
    serve_block("d1", 100, 16'h6000, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
